// File: rtl/shift_sched.sv
// Shared-shifter scheduler: arbitrates two requesters onto one external SHIFT32
// and sequences one- or two-pass shift/rotate operations on it.
module shift_sched (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  REQ,
  input  logic [1:0]  OP0,
  input  logic [1:0]  OP1,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] S0,
  input  logic [31:0] S1,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic [31:0] Y,
  output logic        BUSY,
  output logic [31:0] SH_D,
  output logic [31:0] SH_S,
  output logic        SH_LnR,
  input  logic [31:0] SH_Y
);

  typedef enum logic [1:0] {IDLE, P1, P2, RSP} state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t      state;
  logic [1:0]  op;
  logic [31:0] d;
  logic [31:0] s;
  logic [31:0] acc;
  logic        id;
  logic        last;

  logic        pick;
  logic [1:0]  pick_op;
  logic [31:0] pick_d;
  logic [31:0] pick_s;

  // On a tie the requester that was not served last wins, so sustained
  // contention alternates strictly.
  always_comb begin
    pick = 1'b0;
    if (REQ == 2'b10)
      pick = 1'b1;
    else if (REQ == 2'b11)
      pick = ~last;
    pick_op = pick ? OP1 : OP0;
    pick_d  = pick ? D1  : D0;
    pick_s  = pick ? S1  : S0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      GNT    <= 2'b00;
      DONE   <= 2'b00;
      BUSY   <= 1'b0;
      Y      <= 32'd0;
      SH_D   <= 32'd0;
      SH_S   <= 32'd0;
      SH_LnR <= 1'b0;
      last   <= 1'b1;
      acc    <= 32'd0;
      op     <= OP_SRL;
      d      <= 32'd0;
      s      <= 32'd0;
      id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ != 2'b00) begin
            id     <= pick;
            last   <= pick;
            op     <= pick_op;
            d      <= pick_d;
            s      <= pick_s;
            GNT    <= pick ? 2'b10 : 2'b01;
            BUSY   <= 1'b1;
            SH_D   <= pick_d;
            // Rotates use only the low five bits of the amount.
            SH_S   <= (pick_op == OP_ROL) ? {27'd0, pick_s[4:0]} : pick_s;
            SH_LnR <= (pick_op == OP_SLL) || (pick_op == OP_ROL);
            state  <= P1;
          end
        end
        P1: begin
          acc <= SH_Y;
          if (op == OP_SRL || op == OP_SLL) begin
            Y      <= SH_Y;
            DONE   <= id ? 2'b10 : 2'b01;
            SH_D   <= 32'd0;
            SH_S   <= 32'd0;
            SH_LnR <= 1'b0;
            state  <= RSP;
          end else begin
            // SRA second pass builds the sign-fill mask; ROL second pass
            // brings in the wrapped-around bits (a shift by 32 yields 0).
            SH_LnR <= 1'b0;
            SH_D   <= (op == OP_SRA) ? 32'hFFFF_FFFF : d;
            SH_S   <= (op == OP_SRA) ? s : 32'd32 - {27'd0, s[4:0]};
            state  <= P2;
          end
        end
        P2: begin
          if (op == OP_SRA)
            Y <= acc | (d[31] ? ~SH_Y : 32'd0);
          else
            Y <= acc | SH_Y;
          DONE   <= id ? 2'b10 : 2'b01;
          SH_D   <= 32'd0;
          SH_S   <= 32'd0;
          SH_LnR <= 1'b0;
          state  <= RSP;
        end
        RSP: begin
          DONE  <= 2'b00;
          GNT   <= 2'b00;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: behavioural shifter, transaction-level
// reference model, directed literal cases and randomized traffic.
module tb_shift_sched;

  logic        CLK;
  logic        RST;
  logic [1:0]  REQ;
  logic [1:0]  OP0, OP1;
  logic [31:0] D0, D1, S0, S1;
  logic [1:0]  GNT, DONE;
  logic [31:0] Y;
  logic        BUSY;
  logic [31:0] SH_D, SH_S;
  logic        SH_LnR;
  logic [31:0] SH_Y;

  int checks = 0;
  int errors = 0;

  shift_sched dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .OP0(OP0), .OP1(OP1), .D0(D0), .D1(D1), .S0(S0), .S1(S1),
    .GNT(GNT), .DONE(DONE), .Y(Y), .BUSY(BUSY),
    .SH_D(SH_D), .SH_S(SH_S), .SH_LnR(SH_LnR), .SH_Y(SH_Y)
  );

  // Stand-in for the external SHIFT32: amounts of 32 or more give zero.
  assign SH_Y = (SH_S >= 32'd32) ? 32'd0 : (SH_LnR ? (SH_D << SH_S) : (SH_D >> SH_S));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Direct definition of each operation's result.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s);
    int unsigned r;
    case (op)
      2'b00: return (s >= 32) ? 32'd0 : d >> s;
      2'b01: return (s >= 32) ? 32'd0 : d << s;
      2'b10: return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s);
      default: begin
        r = s % 32;
        return (r == 0) ? d : ((d << r) | (d >> (32 - r)));
      end
    endcase
  endfunction

  // Transaction model: m_pos counts cycles into the current operation.
  int          m_pos = 0;
  int          m_len = 2;
  logic        m_id = 1'b0;
  logic        m_last = 1'b1;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_d = 32'd0;
  logic [31:0] m_s = 32'd0;
  logic [31:0] m_y = 32'd0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pos  = 0;
      m_last = 1'b1;
      m_y    = 32'd0;
    end else if (m_pos == 0) begin
      if (REQ != 2'b00) begin
        m_id   = (REQ == 2'b11) ? !m_last : REQ[1];
        m_last = m_id;
        m_op   = m_id ? OP1 : OP0;
        m_d    = m_id ? D1 : D0;
        m_s    = m_id ? S1 : S0;
        m_len  = (m_op == 2'b10 || m_op == 2'b11) ? 3 : 2;
        m_pos  = 1;
      end
    end else if (m_pos == m_len) begin
      m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == m_len)
        m_y = ref_result(m_op, m_d, m_s);
    end
  end

  always @(negedge CLK) begin
    logic [1:0]  e_onehot;
    logic [31:0] e_shd, e_shs;
    logic        e_lnr;
    e_onehot = m_id ? 2'b10 : 2'b01;
    e_shd = 32'd0;
    e_shs = 32'd0;
    e_lnr = 1'b0;
    if (m_pos == 1) begin
      e_shd = m_d;
      e_shs = (m_op == 2'b11) ? (m_s % 32) : m_s;
      e_lnr = (m_op == 2'b01 || m_op == 2'b11);
    end else if (m_pos == 2 && m_len == 3) begin
      e_shd = (m_op == 2'b10) ? 32'hFFFF_FFFF : m_d;
      e_shs = (m_op == 2'b10) ? m_s : 32 - (m_s % 32);
    end
    check_output("GNT", {30'd0, GNT}, (m_pos != 0) ? {30'd0, e_onehot} : 32'd0);
    check_output("BUSY", {31'd0, BUSY}, {31'd0, m_pos != 0});
    check_output("DONE", {30'd0, DONE}, (m_pos != 0 && m_pos == m_len) ? {30'd0, e_onehot} : 32'd0);
    check_output("Y", Y, m_y);
    check_output("SH_D", SH_D, e_shd);
    check_output("SH_S", SH_S, e_shs);
    check_output("SH_LnR", {31'd0, SH_LnR}, {31'd0, e_lnr});
  end

  logic [31:0] p1_sh_s;
  logic        p1_sh_lnr;

  // Issue one request and wait (bounded) for its DONE pulse.
  task automatic apply_stimulus(input logic rid, input logic [1:0] op, input logic [31:0] d,
                                input logic [31:0] s, input logic [31:0] exp_y, input int exp_lat);
    int  lat;
    bit  got;
    @(negedge CLK);
    REQ = rid ? 2'b10 : 2'b01;
    if (rid) begin OP1 = op; D1 = d; S1 = s; end
    else begin OP0 = op; D0 = d; S0 = s; end
    lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        p1_sh_s   = SH_S;
        p1_sh_lnr = SH_LnR;
        check_output("gnt_p1", {30'd0, GNT}, rid ? 32'd2 : 32'd1);
      end
      if (DONE != 2'b00) got = 1;
    end
    if (!got)
      check_output("done_timeout", 32'd0, 32'd1);
    else begin
      check_output("lit_y", Y, exp_y);
      check_output("lit_done", {30'd0, DONE}, rid ? 32'd2 : 32'd1);
      check_output("lit_latency", lat, exp_lat);
    end
    REQ = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int          seen;
    logic [1:0]  exp_done [4];
    logic [31:0] exp_y [4];
    REQ = 2'b00; OP0 = 2'b00; OP1 = 2'b00;
    D0 = 32'd0; D1 = 32'd0; S0 = 32'd0; S1 = 32'd0;
    RST = 1'b0;
    #1 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_output("rst_y", Y, 32'd0);
    check_output("rst_gnt", {30'd0, GNT}, 32'd0);
    check_output("rst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;

    apply_stimulus(1'b0, 2'b00, 32'h8000_0000, 32'd4, 32'h0800_0000, 2);
    apply_stimulus(1'b1, 2'b10, 32'hF000_0000, 32'd8, 32'hFFF0_0000, 3);
    apply_stimulus(1'b1, 2'b10, 32'hF000_0000, 32'd40, 32'hFFFF_FFFF, 3);
    apply_stimulus(1'b0, 2'b11, 32'h8000_0001, 32'd1, 32'h0000_0003, 3);
    apply_stimulus(1'b1, 2'b11, 32'h8000_0001, 32'd0, 32'h8000_0001, 3);
    apply_stimulus(1'b0, 2'b11, 32'h8000_0001, 32'd33, 32'h0000_0003, 3);
    apply_stimulus(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0001_0000, 32'd0, 2);
    check_output("sll_big_sh_s", p1_sh_s, 32'h0001_0000);
    check_output("sll_big_lnr", {31'd0, p1_sh_lnr}, 32'd1);

    // Sustained contention after reset: alternate starting with requester 0.
    do_reset();
    exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_y    = '{32'd2, 32'd4, 32'd2, 32'd4};
    REQ = 2'b11; OP0 = 2'b01; OP1 = 2'b01;
    D0 = 32'd1; S0 = 32'd1; D1 = 32'd1; S1 = 32'd2;
    seen = 0;
    for (int i = 0; i < 40 && seen < 4; i++) begin
      @(negedge CLK);
      if (DONE != 2'b00) begin
        check_output("alt_done", {30'd0, DONE}, {30'd0, exp_done[seen]});
        check_output("alt_y", Y, exp_y[seen]);
        seen++;
      end
    end
    check_output("alt_count", seen, 32'd4);
    REQ = 2'b00;

    // Abort an SRA in its second pass.
    @(negedge CLK);
    @(negedge CLK);
    REQ = 2'b10; OP1 = 2'b10; D1 = 32'h8000_0000; S1 = 32'd3;
    @(negedge CLK);
    REQ = 2'b00;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check_output("abort_done", {30'd0, DONE}, 32'd0);
    check_output("abort_gnt", {30'd0, GNT}, 32'd0);
    check_output("abort_busy", {31'd0, BUSY}, 32'd0);
    check_output("abort_shd", SH_D, 32'd0);
    check_output("abort_y", Y, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    apply_stimulus(1'b1, 2'b00, 32'h0000_00F0, 32'd4, 32'h0000_000F, 2);

    // Random traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      REQ = 2'($urandom_range(0, 3));
      OP0 = 2'($urandom_range(0, 3));
      OP1 = 2'($urandom_range(0, 3));
      D0  = $urandom;
      D1  = $urandom;
      S0  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      S1  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
    end
    @(negedge CLK);
    REQ = 2'b00;
    repeat (5) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Shared-shifter scheduler: arbitrates two requesters onto one external 32-bit `SHIFT32` instance and sequences multi-pass operations on it. Supported operations are logical right, logical left, arithmetic right and rotate left. The block drives the shifter's `D`/`S`/`LnR` inputs from registers and captures its combinational `Y`. It sits between the ALU/execution units and the single shared shifter datapath.

## Interface
Parameters: none. Data width is fixed at 32.

- `CLK`  in  1  clock; all state updates on the rising edge
- `RST`  in  1  reset; asynchronous, active-high
- `REQ`  in  2  per-requester request; bit i belongs to requester i
- `OP0`, `OP1`  in  2 each  operation code: 00 SRL, 01 SLL, 10 SRA, 11 ROL
- `D0`, `D1`  in  32 each  operand data
- `S0`, `S1`  in  32 each  shift amount, full 32-bit
- `GNT`  out  2  one-hot requester currently being served; 00 when idle
- `DONE`  out  2  one-cycle completion pulse for requester i
- `Y`  out  32  result; valid while `DONE` is nonzero; holds its value otherwise
- `BUSY`  out  1  high in every state except IDLE
- `SH_D`  out  32  data to the shared shifter
- `SH_S`  out  32  shift amount to the shared shifter
- `SH_LnR`  out  1  shifter direction: 1 = left, 0 = right
- `SH_Y`  in  32  combinational result from the shared shifter; sampled in the same cycle it is driven

## Operation
- State machine states: IDLE, P1, P2, RSP.
  - IDLE → P1 when any `REQ` bit is high.
  - P1 → P2 for SRA and ROL.
  - P1 → RSP for SRL and SLL.
  - P2 → RSP always.
  - RSP → IDLE always.
- Arbitration (IDLE only):
  - If exactly one `REQ` bit is high, that requester is granted.
  - If both are high, grant the requester ≠ `last`. `last` updates on each grant and resets to 1, so requester 0 wins the first tie.
- On the grant edge the block latches `OPi`, `Di` and `Si` into internal registers (`op`, `d`, `s`, `id`). Requester inputs are ignored after that edge.
- Shifter drive per pass (`SH_*` registered, loaded on entering P1/P2, zero in IDLE/RSP):
  - SRL: P1 = (`d`, `s`, 0). Y = P1 result.
  - SLL: P1 = (`d`, `s`, 1). Y = P1 result.
  - SRA: P1 = (`d`, `s`, 0) → `acc`. P2 = (32'hFFFFFFFF, `s`, 0) → `m`. Y = `acc` | (`d`[31] ? ~`m` : 0).
  - ROL: `r` = `s`[4:0]. P1 = (`d`, `r`, 1) → `acc`. P2 = (`d`, 32 − `r` computed as a 32-bit unsigned value, 0). Y = `acc` | P2 result.
    - With `r` = 0, P2 shifts by 32 and contributes 0, so Y = `d`.
- Shift amounts ≥ 32 rely on the shifter returning 0:
  - SRL/SLL then yield 0.
  - SRA then yields 32'hFFFFFFFF if `d`[31] = 1, else 0.
  - ROL uses only `s`[4:0].
- `SH_Y` is captured at the end of each P1/P2 cycle.
- RSP: `Y` register holds the final result. `DONE`[`id`] = 1 and `GNT` stays at `id`.
- `REQ`[i] still high in the cycle after `DONE`[i] is treated as a new request.

## Timing
- Reset values: state IDLE, `GNT` = 0, `DONE` = 0, `BUSY` = 0, `Y` = 0, `SH_D` = 0, `SH_S` = 0, `SH_LnR` = 0, `last` = 1, `acc` = 0.
- Reset asserted mid-operation aborts immediately. No `DONE` is produced for the aborted request and no partial result appears on `Y`.
- Latency, counting edge 0 as the edge that samples `REQ` in IDLE:
  - SRL/SLL: `DONE` high in the cycle after edge 1.
  - SRA/ROL: `DONE` high in the cycle after edge 2.
- Throughput: one IDLE cycle between operations. Back-to-back SRL requests from one requester complete every 3 cycles.
- All outputs come directly from registers (Moore). `SH_Y` → capture is a single-cycle combinational path through the shifter.
- `REQ` is sampled only in IDLE. A request arriving in P1/P2/RSP waits. When two requesters are continuously active they alternate strictly.

## Test plan
- Reset then `REQ` = 01, OP0 = SRL, D0 = 32'h80000000, S0 = 4 → `DONE` = 01 two cycles after grant, `Y` = 32'h08000000, `GNT` = 01 during P1/RSP.
- `REQ` = 10, OP1 = SRA, D1 = 32'hF0000000, S1 = 8 → `Y` = 32'hFFF00000, `DONE` = 10 three cycles after grant. Repeat with S1 = 40 → `Y` = 32'hFFFFFFFF.
- ROL with D = 32'h80000001: S = 1 → `Y` = 32'h00000003; S = 0 → `Y` = 32'h80000001; S = 33 → `Y` = 32'h00000003.
- `REQ` = 11 held continuously with both ops SLL (D0 = 1, S0 = 1; D1 = 1, S1 = 2) → grants alternate 0,1,0,1, starting with requester 0. `Y` sequence is 2, 4, 2, 4.
- SLL with S = 32'h00010000 → `Y` = 0. Check `SH_S` = 32'h00010000 and `SH_LnR` = 1 during P1.
- Assert `RST` during P2 of an SRA → all outputs return to 0 asynchronously, no `DONE` pulse, and the next request completes normally.
